// File: rtl/ahb_bus_matrix_input_stage.sv
// Per-master input stage of the AHB bus matrix.
// Samples each master address phase and holds it while the target output port has not
// granted this master; the master is stalled for as long as a transfer is held.
// Optional feature macro: AHB_MTX_SEQ_REMAP_EN (a held SEQ beat is presented as NONSEQ/INCR).
module ahb_bus_matrix_input_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PROT_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [PROT_W-1:0] HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic [1:0]        resp_dec,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              sel_op,
  output logic [ADDR_W-1:0] addr_op,
  output logic [1:0]        trans_op,
  output logic              write_op,
  output logic [2:0]        size_op,
  output logic [2:0]        burst_op,
  output logic [PROT_W-1:0] prot_op,
  output logic              mastlock_op,
  output logic              held_tran_op
);

  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;
  localparam logic [2:0] BurstIncr   = 3'b001;
  localparam logic [1:0] RespOkay    = 2'b00;

  logic              pend_q, pend_d;
  logic              dphase_q, dphase_d;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [1:0]        hold_trans_q;
  logic              hold_write_q;
  logic [2:0]        hold_size_q;
  logic [2:0]        hold_burst_q;
  logic [PROT_W-1:0] hold_prot_q;
  logic              hold_mastlock_q;

  logic tran_valid;
  logic err_last;
  logic held_accept;
  logic accept;

  // Qualify the address phase and detect acceptance / cancellation events
  always_comb begin
    tran_valid  = HSELS & HREADYS & HTRANSS[1];
    // Any non-OKAY response is a two-cycle response; its last cycle cancels the held transfer
    err_last    = dphase_q & (resp_dec != RespOkay) & readyout_dec;
    held_accept = pend_q & active_dec & readyout_dec & ~err_last;
    accept      = (tran_valid & active_dec) | held_accept;
  end

  // Next state of the pending and data-phase flags
  always_comb begin
    pend_d   = pend_q;
    dphase_d = dphase_q;
    if (pend_q) begin
      if (held_accept || err_last) pend_d = 1'b0;
    end else if (tran_valid && !active_dec) begin
      pend_d = 1'b1;
    end
    if (accept) begin
      dphase_d = 1'b1;
    end else if (readyout_dec) begin
      dphase_d = 1'b0;
    end
  end

  // Flag registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_q   <= 1'b0;
      dphase_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      dphase_q <= dphase_d;
    end
  end

  // Holding registers capture every valid address phase
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hold_addr_q     <= '0;
      hold_trans_q    <= '0;
      hold_write_q    <= 1'b0;
      hold_size_q     <= '0;
      hold_burst_q    <= '0;
      hold_prot_q     <= '0;
      hold_mastlock_q <= 1'b0;
    end else if (tran_valid) begin
      hold_addr_q     <= HADDRS;
      hold_trans_q    <= HTRANSS;
      hold_write_q    <= HWRITES;
      hold_size_q     <= HSIZES;
      hold_burst_q    <= HBURSTS;
      hold_prot_q     <= HPROTS;
      hold_mastlock_q <= HMASTLOCKS;
    end
  end

  // Output mux: held copy while pending, otherwise zero-latency pass-through
  always_comb begin
    held_tran_op = pend_q;
    if (pend_q) begin
      sel_op      = 1'b1;
      addr_op     = hold_addr_q;
      trans_op    = hold_trans_q;
      write_op    = hold_write_q;
      size_op     = hold_size_q;
      burst_op    = hold_burst_q;
      prot_op     = hold_prot_q;
      mastlock_op = hold_mastlock_q;
`ifdef AHB_MTX_SEQ_REMAP_EN
      // A resumed burst beat must restart arbitration as a fresh INCR burst
      if (hold_trans_q == TransSeq) begin
        trans_op = TransNonseq;
        burst_op = BurstIncr;
      end
`endif
    end else begin
      sel_op      = HSELS & HTRANSS[1];
      addr_op     = HADDRS;
      trans_op    = HTRANSS;
      write_op    = HWRITES;
      size_op     = HSIZES;
      burst_op    = HBURSTS;
      prot_op     = HPROTS;
      mastlock_op = HMASTLOCKS;
    end
  end

  // Ready/response back to the master; a two-cycle response overrides the stall
  always_comb begin
    HRESPS     = dphase_q ? resp_dec : RespOkay;
    HREADYOUTS = 1'b1;
    if (dphase_q && (resp_dec != RespOkay)) begin
      HREADYOUTS = readyout_dec;
    end else if (pend_q) begin
      HREADYOUTS = 1'b0;
    end else if (dphase_q) begin
      HREADYOUTS = readyout_dec;
    end
  end

endmodule

// File: tb/tb_ahb_bus_matrix_input_stage.sv
// Self-checking bench for ahb_bus_matrix_input_stage: directed scenarios plus a randomized
// run against a transaction-level reference model (pending queue + data-phase bit).
module tb_ahb_bus_matrix_input_stage;

  logic        HCLK;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        sel_op;
  logic [31:0] addr_op;
  logic [1:0]  trans_op;
  logic        write_op;
  logic [2:0]  size_op;
  logic [2:0]  burst_op;
  logic [3:0]  prot_op;
  logic        mastlock_op;
  logic        held_tran_op;

  int checks = 0;
  int errors = 0;

  ahb_bus_matrix_input_stage #(.ADDR_W(32), .PROT_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .active_dec(active_dec),
    .readyout_dec(readyout_dec), .resp_dec(resp_dec), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op),
    .write_op(write_op), .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
    .mastlock_op(mastlock_op), .held_tran_op(held_tran_op)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } xfer_t;

  // Reference model: transfers waiting for a grant, and whether a data phase is outstanding
  xfer_t held_q[$];
  bit    m_dp;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_idle();
    HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0; HSIZES = 3'b010;
    HBURSTS = 3'b000; HPROTS = 4'b0011; HMASTLOCKS = 1'b0; HREADYS = 1'b1;
    active_dec = 1'b0; readyout_dec = 1'b1; resp_dec = 2'b00;
  endtask

  task automatic drive_xfer(input logic [31:0] a, input logic [1:0] t, input logic w,
                            input logic [2:0] b);
    HSELS = 1'b1; HADDRS = a; HTRANSS = t; HWRITES = w; HBURSTS = b; HREADYS = 1'b1;
  endtask

  function automatic xfer_t live_xfer();
    xfer_t x;
    x.addr = HADDRS; x.trans = HTRANSS; x.write = HWRITES; x.size = HSIZES;
    x.burst = HBURSTS; x.prot = HPROTS; x.lock = HMASTLOCKS;
    return x;
  endfunction

  function automatic xfer_t exp_ops();
    xfer_t x;
    if (held_q.size() == 0) return live_xfer();
    x = held_q[0];
`ifdef AHB_MTX_SEQ_REMAP_EN
    if (x.trans == 2'b11) begin
      x.trans = 2'b10;
      x.burst = 3'b001;
    end
`endif
    return x;
  endfunction

  // {HREADYOUTS, HRESPS, sel_op, held_tran_op}
  function automatic logic [4:0] exp_ctrl();
    logic rdy;
    logic held;
    held = (held_q.size() != 0);
    if (m_dp && resp_dec == 2'b10) rdy = readyout_dec;
    else if (held)                 rdy = 1'b0;
    else if (m_dp)                 rdy = readyout_dec;
    else                           rdy = 1'b1;
    return {rdy, (m_dp ? resp_dec : 2'b00), (held ? 1'b1 : (HSELS & HTRANSS[1])), held};
  endfunction

  task automatic model_step();
    bit valid, err_last, issue, cancel;
    valid    = HSELS && HREADYS && HTRANSS[1];
    err_last = m_dp && (resp_dec == 2'b10) && readyout_dec;
    issue    = (held_q.size() != 0) && active_dec && readyout_dec && !err_last;
    cancel   = (held_q.size() != 0) && err_last;
    if ((valid && active_dec) || issue) m_dp = 1'b1;
    else if (readyout_dec)              m_dp = 1'b0;
    if (issue || cancel) held_q.delete();
    if (valid && !active_dec) held_q.push_back(live_xfer());
  endtask

  task automatic test_reset();
    drive_idle();
    HRESETn = 1'b0;
    tick(); tick();
    HRESETn = 1'b1;
    #2;
    checks++;
    if ({HREADYOUTS, HRESPS, held_tran_op, sel_op, trans_op} !== 7'b1_00_0_0_00) begin
      errors++;
      $display("FAIL reset_state: got %b required 1000000",
               {HREADYOUTS, HRESPS, held_tran_op, sel_op, trans_op});
    end
    tick();
  endtask

  task automatic test_direct_pass();
    drive_xfer(32'h2000_0000, 2'b10, 1'b0, 3'b000);
    active_dec = 1'b1;
    #2;
    checks++;
    if ({addr_op, held_tran_op, sel_op, trans_op} !== {32'h2000_0000, 1'b0, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL direct_pass_ops: got addr=%h held=%b sel=%b trans=%b required 20000000 0 1 10",
               addr_op, held_tran_op, sel_op, trans_op);
    end
    tick();
    drive_idle();
    readyout_dec = 1'b0;
    #2;
    checks++;
    if (HREADYOUTS !== 1'b0) begin
      errors++;
      $display("FAIL direct_pass_wait: HREADYOUTS got %b required 0", HREADYOUTS);
    end
    readyout_dec = 1'b1;
    #1;
    checks++;
    if (HREADYOUTS !== 1'b1) begin
      errors++;
      $display("FAIL direct_pass_done: HREADYOUTS got %b required 1", HREADYOUTS);
    end
    tick();
  endtask

  task automatic test_held();
    int low_cnt;
    low_cnt = 0;
    drive_xfer(32'h4000_0010, 2'b10, 1'b1, 3'b000);
    tick();
    drive_idle();
    HREADYS = 1'b0;
    for (int p = 0; p < 3; p++) begin
      active_dec = (p == 2);
      #2;
      if (HREADYOUTS === 1'b0) low_cnt++;
      checks++;
      if ({addr_op, write_op, held_tran_op, sel_op} !== {32'h4000_0010, 1'b1, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL held_ops[%0d]: got addr=%h w=%b held=%b sel=%b required 40000010 1 1 1",
                 p, addr_op, write_op, held_tran_op, sel_op);
      end
      tick();
    end
    checks++;
    if (low_cnt != 3) begin
      errors++;
      $display("FAIL held_stall_cycles: got %0d required 3", low_cnt);
    end
    drive_idle();
    #2;
    checks++;
    if ({held_tran_op, HREADYOUTS, sel_op} !== 3'b010) begin
      errors++;
      $display("FAIL held_release: got held/rdy/sel=%b required 010",
               {held_tran_op, HREADYOUTS, sel_op});
    end
    tick();
  endtask

  task automatic test_error();
    drive_xfer(32'h1000_0000, 2'b10, 1'b0, 3'b000);
    active_dec = 1'b1;
    tick();
    drive_idle();
    HREADYS = 1'b0; resp_dec = 2'b10; readyout_dec = 1'b0;
    #2;
    checks++;
    if ({HRESPS, HREADYOUTS} !== 3'b10_0) begin
      errors++;
      $display("FAIL error_first: got resp/rdy=%b required 100", {HRESPS, HREADYOUTS});
    end
    tick();
    HREADYS = 1'b1; readyout_dec = 1'b1;
    #2;
    checks++;
    if ({HRESPS, HREADYOUTS} !== 3'b10_1) begin
      errors++;
      $display("FAIL error_second: got resp/rdy=%b required 101", {HRESPS, HREADYOUTS});
    end
    tick();
    drive_idle();
    #2;
    checks++;
    if ({HRESPS, HREADYOUTS} !== 3'b00_1) begin
      errors++;
      $display("FAIL error_after: got resp/rdy=%b required 001", {HRESPS, HREADYOUTS});
    end
    tick();
  endtask

  task automatic test_error_cancel();
    drive_xfer(32'h1000_0100, 2'b10, 1'b0, 3'b000);
    active_dec = 1'b1;
    tick();
    // First ERROR cycle while the master already presents the next transfer, not granted
    drive_xfer(32'h5000_0000, 2'b10, 1'b0, 3'b000);
    active_dec = 1'b0; resp_dec = 2'b10; readyout_dec = 1'b0;
    tick();
    drive_idle();
    resp_dec = 2'b10; readyout_dec = 1'b1;
    #2;
    checks++;
    if ({held_tran_op, HRESPS, HREADYOUTS} !== 4'b1_10_1) begin
      errors++;
      $display("FAIL cancel_second_err: got held/resp/rdy=%b required 1101",
               {held_tran_op, HRESPS, HREADYOUTS});
    end
    tick();
    resp_dec = 2'b00;
    #2;
    checks++;
    if ({held_tran_op, sel_op, HRESPS, HREADYOUTS} !== 5'b0_0_00_1) begin
      errors++;
      $display("FAIL cancel_after: got held/sel/resp/rdy=%b required 00001",
               {held_tran_op, sel_op, HRESPS, HREADYOUTS});
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    drive_xfer(32'h6000_0000, 2'b10, 1'b1, 3'b000);
    tick();
    drive_idle();
    HREADYS = 1'b0;
    HRESETn = 1'b0;
    #2;
    checks++;
    if ({held_tran_op, HREADYOUTS} !== 2'b10) begin
      errors++;
      $display("FAIL reset_not_async: got held/rdy=%b required 10", {held_tran_op, HREADYOUTS});
    end
    tick();
    HRESETn = 1'b1;
    #1;
    checks++;
    if ({HREADYOUTS, held_tran_op, trans_op} !== 4'b1_0_00) begin
      errors++;
      $display("FAIL reset_mid_hold: got rdy/held/trans=%b required 1000",
               {HREADYOUTS, held_tran_op, trans_op});
    end
    tick();
  endtask

  task automatic test_seq_remap();
    logic [4:0] exp_tb;
`ifdef AHB_MTX_SEQ_REMAP_EN
    exp_tb = 5'b10_001;
`else
    exp_tb = 5'b11_011;
`endif
    drive_xfer(32'h7000_0004, 2'b11, 1'b0, 3'b011);
    #2;
    checks++;
    if ({trans_op, burst_op} !== 5'b11_011) begin
      errors++;
      $display("FAIL seq_live: got trans/burst=%b required 11011", {trans_op, burst_op});
    end
    tick();
    drive_idle();
    HREADYS = 1'b0;
    #2;
    checks++;
    if ({trans_op, burst_op} !== exp_tb) begin
      errors++;
      $display("FAIL seq_held: got trans/burst=%b required %b", {trans_op, burst_op}, exp_tb);
    end
    active_dec = 1'b1;
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    logic [4:0] ctl_exp;
    xfer_t      ops_exp;
    drive_idle();
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    held_q.delete();
    m_dp = 1'b0;
    for (int n = 0; n < 400; n++) begin
      HSELS        = ($urandom_range(0, 3) != 0);
      HADDRS       = $urandom;
      HTRANSS      = 2'($urandom_range(0, 3));
      HWRITES      = 1'($urandom_range(0, 1));
      HSIZES       = 3'($urandom_range(0, 7));
      HBURSTS      = 3'($urandom_range(0, 7));
      HPROTS       = 4'($urandom_range(0, 15));
      HMASTLOCKS   = 1'($urandom_range(0, 1));
      // A stalled master never sees HREADY high, so no new transfer arrives while one is held
      HREADYS      = (held_q.size() != 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      active_dec   = 1'($urandom_range(0, 1));
      readyout_dec = ($urandom_range(0, 3) != 0);
      resp_dec     = ($urandom_range(0, 6) == 0) ? 2'b10 : 2'b00;
      #2;
      ctl_exp = exp_ctrl();
      ops_exp = exp_ops();
      checks++;
      if ({HREADYOUTS, HRESPS, sel_op, held_tran_op} !== ctl_exp) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got rdy/resp/sel/held=%b required %b", n,
                 {HREADYOUTS, HRESPS, sel_op, held_tran_op}, ctl_exp);
      end
      checks++;
      if ({addr_op, trans_op, write_op, size_op, burst_op, prot_op, mastlock_op} !== ops_exp)
      begin
        errors++;
        $display("FAIL rand_ops[%0d]: got %h required %h", n,
                 {addr_op, trans_op, write_op, size_op, burst_op, prot_op, mastlock_op},
                 ops_exp);
      end
      model_step();
      tick();
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    drive_idle();
    #1;
    test_reset();
    test_direct_pass();
    test_held();
    test_error();
    test_error_cancel();
    test_reset_mid_hold();
    test_seq_remap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
